// File: rtl/drp_sample_responder.sv
// DRP responder modelling the XADC status/config register file: samples land left-justified in status
// registers and DRP reads return them after RD_LATENCY cycles. Optional min/max tracking: `DRP_MINMAX_EN.
module drp_sample_responder #(
    parameter int RD_LATENCY = 4,
    parameter int NUM_CFG    = 4
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [4:0]  sample_ch,
    input  logic [11:0] sample_data,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        busy_out,
    output logic        eoc_out,
    output logic [4:0]  channel_out,
    output logic        err_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        we_reg;
    logic [6:0]  addr_reg;
    logic [15:0] di_reg;
    logic [15:0] snap_reg;
    logic [15:0] status_reg [32];
    logic [15:0] cfg_reg [NUM_CFG];
    logic        eoc_reg;
    logic [4:0]  ch_reg;
    logic        err_reg;
    logic [15:0] rd_data;
    logic        accept;

`ifdef DRP_MINMAX_EN
    logic [15:0] max_reg;
    logic [15:0] min_reg;
`endif

    assign accept = (state_reg == S_IDLE) && den_in;

    // Read data is taken from the registers before this cycle's sample update lands.
    always_comb begin
        rd_data = 16'h0000;
        if (daddr_in < 7'h20) begin
            rd_data = status_reg[daddr_in[4:0]];
        end
        for (int i = 0; i < NUM_CFG; i++) begin
            if (daddr_in == 7'(64 + i)) begin
                rd_data = cfg_reg[i];
            end
        end
`ifdef DRP_MINMAX_EN
        if (daddr_in == 7'h23) rd_data = max_reg;
        if (daddr_in == 7'h27) rd_data = min_reg;
`endif
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (den_in) begin
                    state_next = (RD_LATENCY == 1) ? S_RESP : S_WAIT;
                    cnt_next   = 4'(RD_LATENCY - 1);
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= 7'd0;
            di_reg    <= 16'h0000;
            snap_reg  <= 16'h0000;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg   <= dwe_in;
                addr_reg <= daddr_in;
                di_reg   <= di_in;
                snap_reg <= dwe_in ? 16'h0000 : rd_data;
            end
            if (den_in && busy_out) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Config writes commit on the acknowledge cycle; writes anywhere else are acked and dropped.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                cfg_reg[i] <= 16'h0000;
            end
        end else if (state_reg == S_RESP && we_reg) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (addr_reg == 7'(64 + i)) begin
                    cfg_reg[i] <= di_reg;
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                status_reg[i] <= 16'h0000;
            end
            eoc_reg <= 1'b0;
            ch_reg  <= 5'd0;
        end else begin
            eoc_reg <= sample_valid;
            if (sample_valid) begin
                status_reg[sample_ch] <= {sample_data, 4'h0};
                ch_reg                <= sample_ch;
            end
        end
    end

`ifdef DRP_MINMAX_EN
    // Equal samples leave the extremes untouched (strict compares).
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            max_reg <= 16'h0000;
            min_reg <= 16'hFFFF;
        end else if (sample_valid && sample_ch == 5'h03) begin
            if (sample_data > max_reg[15:4]) max_reg <= {sample_data, 4'h0};
            if (sample_data < min_reg[15:4]) min_reg <= {sample_data, 4'h0};
        end
    end
`endif

    assign drdy_out    = (state_reg == S_RESP);
    assign do_out      = drdy_out ? snap_reg : 16'h0000;
    assign busy_out    = (state_reg != S_IDLE);
    assign eoc_out     = eoc_reg;
    assign channel_out = ch_reg;
    assign err_out     = err_reg;

endmodule

// File: tb/tb_drp_sample_responder.sv
// Scoreboard bench for drp_sample_responder: directed DRP/sample vectors push expected responses,
// a negedge monitor pops and checks data and arrival cycle on every drdy_out pulse.
module tb_drp_sample_responder;

    localparam int L = 4;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [4:0]  sample_ch;
    logic [11:0] sample_data;
    logic        den_in;
    logic        dwe_in;
    logic [6:0]  daddr_in;
    logic [15:0] di_in;
    logic [15:0] do_out;
    logic        drdy_out;
    logic        busy_out;
    logic        eoc_out;
    logic [4:0]  channel_out;
    logic        err_out;

    typedef struct {
        logic [15:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    drp_sample_responder #(.RD_LATENCY(L), .NUM_CFG(4)) dut (
        .sysclk(sysclk), .rst_n(rst_n),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
        .den_in(den_in), .dwe_in(dwe_in), .daddr_in(daddr_in), .di_in(di_in),
        .do_out(do_out), .drdy_out(drdy_out), .busy_out(busy_out),
        .eoc_out(eoc_out), .channel_out(channel_out), .err_out(err_out)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every drdy pulse must match the head of the scoreboard, data and cycle.
    always @(negedge sysclk) begin
        if (rst_n === 1'b1) begin
            if (drdy_out) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_drdy", 32'(do_out), 32'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_data"}, 32'(do_out), 32'(e.data));
                    chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
                end
            end else if (do_out !== 16'h0000) begin
                chk("do_out_idle_zero", 32'(do_out), 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drp(input string name, input logic we, input logic [6:0] addr,
                       input logic [15:0] di, input logic [15:0] exp);
        den_in = 1'b1; dwe_in = we; daddr_in = addr; di_in = di;
        exp_q.push_back('{data: exp, due: cyc + L, name: name});
        step();
        den_in = 1'b0; dwe_in = 1'b0;
        repeat (L) step();
    endtask

    task automatic sample(input logic [4:0] ch, input logic [11:0] data);
        sample_valid = 1'b1; sample_ch = ch; sample_data = data;
        step();
        sample_valid = 1'b0;
    endtask

    logic [15:0] exp_max, exp_min;

    initial begin
        rst_n = 1'b0;
        sample_valid = 1'b0; sample_ch = '0; sample_data = '0;
        den_in = 1'b0; dwe_in = 1'b0; daddr_in = '0; di_in = '0;
        repeat (3) step();
        chk("rst_drdy", 32'(drdy_out), 0);
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_eoc", 32'(eoc_out), 0);
        chk("rst_err", 32'(err_out), 0);
        chk("rst_do", 32'(do_out), 0);
        rst_n = 1'b1;
        step();

        // Sample then read back, eoc timing
        sample(5'h03, 12'hABC);
        chk("eoc_pulse", 32'(eoc_out), 1);
        chk("channel_out", 32'(channel_out), 32'h03);
        step();
        chk("eoc_single", 32'(eoc_out), 0);
        drp("rd_03", 1'b0, 7'h03, 16'h0, 16'hABC0);

        // Config and read-only writes
        drp("wr_41", 1'b1, 7'h41, 16'h1234, 16'h0000);
        drp("rd_41", 1'b0, 7'h41, 16'h0, 16'h1234);
        drp("wr_14", 1'b1, 7'h14, 16'hFFFF, 16'h0000);
        drp("rd_14_unch", 1'b0, 7'h14, 16'h0, 16'h0000);
        drp("rd_7f", 1'b0, 7'h7F, 16'h0, 16'h0000);
        drp("rd_42", 1'b0, 7'h42, 16'h0, 16'h0000);

        // Same-cycle sample and read: old value first
        sample(5'h14, 12'h050);
        sample_valid = 1'b1; sample_ch = 5'h14; sample_data = 12'h100;
        den_in = 1'b1; dwe_in = 1'b0; daddr_in = 7'h14;
        exp_q.push_back('{data: 16'h0500, due: cyc + L, name: "rd_14_old"});
        step();
        sample_valid = 1'b0; den_in = 1'b0;
        repeat (L) step();
        drp("rd_14_new", 1'b0, 7'h14, 16'h0, 16'h1000);

        // den every cycle: 1st and 6th accepted
        for (int i = 0; i < 8; i++) begin
            den_in = 1'b1; dwe_in = 1'b0; daddr_in = 7'h41;
            if (i == 0 || i == 5) begin
                exp_q.push_back('{data: 16'h1234, due: cyc + L, name: $sformatf("burst_%0d", i)});
            end
            step();
        end
        den_in = 1'b0;
        chk("err_set", 32'(err_out), 1);
        repeat (L + 2) step();
        chk("err_sticky", 32'(err_out), 1);

        // Min/max tracking of channel 3
        sample(5'h03, 12'h800);
        sample(5'h03, 12'h200);
        sample(5'h03, 12'hF00);
        sample(5'h03, 12'h200);
        step();
`ifdef DRP_MINMAX_EN
        exp_max = 16'hF000; exp_min = 16'h2000;
`else
        exp_max = 16'h0000; exp_min = 16'h0000;
`endif
        drp("rd_max", 1'b0, 7'h23, 16'h0, exp_max);
        drp("rd_min", 1'b0, 7'h27, 16'h0, exp_min);

        // Reset mid-WAIT drops the in-flight read
        den_in = 1'b1; dwe_in = 1'b0; daddr_in = 7'h03;
        step();
        den_in = 1'b0;
        step();
        chk("busy_before_rst", 32'(busy_out), 1);
        rst_n = 1'b0;
        #1;
        chk("rst2_busy", 32'(busy_out), 0);
        chk("rst2_err", 32'(err_out), 0);
        chk("rst2_channel", 32'(channel_out), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            chk("rst2_no_drdy", 32'(drdy_out), 0);
        end
        step();
        rst_n = 1'b1;
        repeat (L + 2) step();
        drp("rd_03_after_rst", 1'b0, 7'h03, 16'h0, 16'h0000);
        drp("rd_41_after_rst", 1'b0, 7'h41, 16'h0, 16'h0000);
        chk("err_after_rst", 32'(err_out), 0);

        begin
            int budget = 50;
            while (exp_q.size() != 0 && budget > 0) begin
                step();
                budget--;
            end
            if (exp_q.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
